// File: rtl/mem_loader.sv
// Byte-stream image loader: parses SYNC/LEN/DATA/CSUM frames and writes big-endian
// 32-bit words to consecutive memory addresses starting at BASE_ADDR.
module mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] addr,
  output logic [31:0] wdata,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_wordIdx;
  logic [1:0]  r_byteIdx;
  logic [23:0] r_word;
  logic [7:0]  r_csum;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_done;
  logic        r_err;
  logic        w_accept;

  // The WRITE cycle is the only one that cannot take a byte.
  assign rx_ready = (r_state != S_WRITE);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = rx_valid && rx_ready;

  assign addr  = r_addr;
  assign wdata = r_wdata;
  assign we    = r_we;
  assign done  = r_done;
  assign err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= 16'h0000;
      r_wordIdx <= 16'h0000;
      r_byteIdx <= 2'd0;
      r_word    <= 24'h000000;
      r_csum    <= 8'h00;
      r_addr    <= BASE_ADDR;
      r_wdata   <= 32'h00000000;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (rx_data == SYNC_BYTE)) begin
            r_state   <= S_LEN_H;
            r_err     <= 1'b0;
            r_csum    <= 8'h00;
            r_byteIdx <= 2'd0;
          end
        end
        S_LEN_H: begin
          if (w_accept) begin
            r_count[15:8] <= rx_data;
            r_state       <= S_LEN_L;
          end
        end
        S_LEN_L: begin
          if (w_accept) begin
            r_count[7:0] <= rx_data;
            r_wordIdx    <= 16'h0000;
            r_byteIdx    <= 2'd0;
            if ({r_count[15:8], rx_data} == 16'h0000) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum    <= r_csum ^ rx_data;
            r_word    <= {r_word[15:0], rx_data};
            r_byteIdx <= r_byteIdx + 2'd1;
            // Fourth byte completes the word; address and data register together.
            if (r_byteIdx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= BASE_ADDR + r_wordIdx;
              r_wdata <= {r_word, rx_data};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_wordIdx <= r_wordIdx + 16'd1;
          if ((r_wordIdx + 16'd1) == r_count) begin
            r_state <= S_CSUM;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_err   <= (rx_data != r_csum);
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a frame parser model predicts memory writes,
// done pulses and the checksum flag for two instances (BASE 0000 and FFFF).
module tb_mem_loader;

  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic        rdy0, rdy1, we0, we1, busy0, busy1, done0, done1, err0, err1;
  logic [15:0] addr0, addr1;
  logic [31:0] wd0, wd1;

  int checks = 0;
  int errors = 0;

  logic [47:0] wrQ0[$];
  logic [47:0] wrQ1[$];
  logic [47:0] expQ0[$];
  logic [47:0] expQ1[$];
  logic [7:0]  frameQ[$];
  int          doneCnt = 0;
  int          rdyLowCnt = 0;
  int          expDone = 0;
  int          expWords = 0;
  logic        expErr = 1'b0;

  mem_loader #(.BASE_ADDR(BASE0), .SYNC_BYTE(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .addr(addr0), .wdata(wd0), .we(we0),
    .busy(busy0), .done(done0), .err(err0)
  );

  mem_loader #(.BASE_ADDR(BASE1), .SYNC_BYTE(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .addr(addr1), .wdata(wd1), .we(we1),
    .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  // Memory-side observer: we is a one-cycle pulse, so each negedge with we=1 is one write.
  always @(negedge clk) begin
    if (we0) wrQ0.push_back({addr0, wd0});
    if (we1) wrQ1.push_back({addr1, wd1});
    if (done0) doneCnt++;
    if (!rdy0) rdyLowCnt++;
  end

  task automatic clearMon();
    wrQ0.delete();
    wrQ1.delete();
    doneCnt = 0;
    rdyLowCnt = 0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    logic rdy;
    logic accepted;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      rdy = rdy0;
      @(posedge clk);
      if (rdy) accepted = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL byte_accept_timeout byte %h accepted %b required 1", b, accepted);
    end
  endtask

  task automatic sendStream(input int maxGap);
    for (int i = 0; i < frameQ.size(); i++) begin
      sendByte(frameQ[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference parser: walks the byte stream by frame rules, not by cycles.
  task automatic modelStream();
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    expQ0.delete();
    expQ1.delete();
    expDone = 0;
    expWords = 0;
    i = 0;
    while (i < frameQ.size()) begin
      if (frameQ[i] != 8'hA5) begin
        i++;
      end else begin
        n = int'({frameQ[i+1], frameQ[i+2]});
        i += 3;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
          w = {frameQ[i], frameQ[i+1], frameQ[i+2], frameQ[i+3]};
          x = x ^ frameQ[i] ^ frameQ[i+1] ^ frameQ[i+2] ^ frameQ[i+3];
          expQ0.push_back({BASE0 + 16'(k), w});
          expQ1.push_back({BASE1 + 16'(k), w});
          i += 4;
        end
        expWords += n;
        expErr = (frameQ[i] != x);
        expDone++;
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy0); end
    checks++; if (we0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", we0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err0); end
    checks++; if (addr0 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr0 got %h want 0000", addr0); end
    checks++; if (addr1 !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_addr1 got %h want ffff", addr1); end
    checks++; if (wd0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", wd0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_ready got %b want 1", rdy0); end
    rst_n = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_ignored busy got %b want 0", busy0); end
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [8] = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    clearMon();
    for (int i = 0; i < 7; i++) sendByte(bytes[i], 0);
    sendByte(bytes[7], 0);
    checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL single_done got %b want 1", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %b want 0", busy0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL single_err got %b want 0", err0); end
    repeat (3) @(negedge clk);
    checks++; if (wrQ0.size() != 1) begin errors++; $display("[TB] FAIL single_wcount got %0d want 1", wrQ0.size()); end
    checks++; if (wrQ0[0] !== {16'h0000, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL single_write got %h want 0000deadbeef", wrQ0[0]); end
    checks++; if (wrQ1[0] !== {16'hFFFF, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL single_write_base got %h want ffffdeadbeef", wrQ1[0]); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL single_done_count got %0d want 1", doneCnt); end
    checks++; if (rdyLowCnt != 1) begin errors++; $display("[TB] FAIL single_ready_low got %0d want 1", rdyLowCnt); end
    checks++; if (addr0 !== 16'h0000 || wd0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_hold got %h/%h want 0000/deadbeef", addr0, wd0); end
  endtask

  task automatic test_empty_frame();
    clearMon();
    sendByte(8'hA5, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL empty_done got %b want 1", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL empty_err got %b want 0", err0); end
    sendByte(8'hA5, 1); sendByte(8'h00, 0); sendByte(8'h00, 2); sendByte(8'h01, 0);
    checks++; if (err0 !== 1'b1) begin errors++; $display("[TB] FAIL empty_bad_err got %b want 1", err0); end
    sendByte(8'h00, 0); sendByte(8'h11, 1);
    repeat (2) @(negedge clk);
    checks++; if (err0 !== 1'b1) begin errors++; $display("[TB] FAIL empty_err_sticky got %b want 1", err0); end
    sendByte(8'hA5, 0);
    checks++; if (err0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("[TB] FAIL empty_err_clear got err %b busy %b want 0 1", err0, busy0); end
    sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    repeat (3) @(negedge clk);
    checks++; if (wrQ0.size() != 0) begin errors++; $display("[TB] FAIL empty_no_we got %0d want 0", wrQ0.size()); end
    checks++; if (doneCnt != 3) begin errors++; $display("[TB] FAIL empty_done_count got %0d want 3", doneCnt); end
  endtask

  task automatic test_gaps_three_words();
    clearMon();
    frameQ = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
               8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    modelStream();
    sendStream(3);
    checks++; if (wrQ0.size() != expQ0.size()) begin errors++; $display("[TB] FAIL gaps_wcount got %0d want %0d", wrQ0.size(), expQ0.size()); end
    for (int k = 0; k < expQ0.size(); k++) begin
      checks++; if (wrQ0[k] !== expQ0[k]) begin errors++; $display("[TB] FAIL gaps_write%0d got %h want %h", k, wrQ0[k], expQ0[k]); end
    end
    checks++; if (rdyLowCnt != 3) begin errors++; $display("[TB] FAIL gaps_ready_low got %0d want 3", rdyLowCnt); end
    checks++; if (err0 !== 1'b0 || doneCnt != 1) begin errors++; $display("[TB] FAIL gaps_end got err %b done %0d want 0 1", err0, doneCnt); end
  endtask

  task automatic test_garbage();
    logic [7:0] junk [3] = '{8'h00, 8'hFF, 8'h5A};
    clearMon();
    for (int i = 0; i < 3; i++) begin
      sendByte(junk[i], 1);
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL garbage_busy%0d got %b want 0", i, busy0); end
    end
    frameQ = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    modelStream();
    sendStream(2);
    checks++; if (wrQ0.size() != 1 || wrQ0[0] !== expQ0[0]) begin errors++; $display("[TB] FAIL garbage_write got %h want %h", wrQ0[0], expQ0[0]); end
    checks++; if (err0 !== 1'b0 || doneCnt != 1) begin errors++; $display("[TB] FAIL garbage_end got err %b done %0d want 0 1", err0, doneCnt); end
  endtask

  task automatic test_wrap();
    clearMon();
    frameQ = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    sendStream(1);
    checks++; if (wrQ1.size() != 2) begin errors++; $display("[TB] FAIL wrap_wcount got %0d want 2", wrQ1.size()); end
    checks++; if (wrQ1[0] !== {16'hFFFF, 32'h11223344}) begin errors++; $display("[TB] FAIL wrap_first got %h want ffff11223344", wrQ1[0]); end
    checks++; if (wrQ1[1] !== {16'h0000, 32'h55667788}) begin errors++; $display("[TB] FAIL wrap_second got %h want 000055667788", wrQ1[1]); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err got %b want 0", err1); end
    checks++; if (wrQ0[1] !== {16'h0001, 32'h55667788}) begin errors++; $display("[TB] FAIL wrap_base0 got %h want 000155667788", wrQ0[1]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] head [9] = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    clearMon();
    for (int i = 0; i < 9; i++) sendByte(head[i], 0);
    rst_n = 1'b0;
    #1;
    checks++; if (we0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state got we %b busy %b want 0 0", we0, busy0); end
    checks++; if (wrQ0.size() != 1 || wrQ0[0] !== {16'h0000, 32'hAABBCCDD}) begin errors++; $display("[TB] FAIL midreset_kept got %h want 0000aabbccdd", wrQ0[0]); end
    checks++; if (wrQ1[0] !== {16'hFFFF, 32'hAABBCCDD}) begin errors++; $display("[TB] FAIL midreset_kept1 got %h want ffffaabbccdd", wrQ1[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendByte(8'hA5, 0); sendByte(8'h00, 0); sendByte(8'h01, 0);
    sendByte(8'h01, 0); sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 0);
    checks++; if (we0 !== 1'b1) begin errors++; $display("[TB] FAIL write_cycle_we got %b want 1", we0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (we0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL write_reset got we %b busy %b want 0 0", we0, busy0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearMon();
    frameQ = '{8'h33, 8'h44, 8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC9};
    modelStream();
    sendStream(1);
    checks++; if (wrQ0.size() != 1 || wrQ0[0] !== expQ0[0]) begin errors++; $display("[TB] FAIL after_reset_write got %h want %h", wrQ0[0], expQ0[0]); end
    checks++; if (err0 !== 1'b0 || doneCnt != 1) begin errors++; $display("[TB] FAIL after_reset_end got err %b done %0d want 0 1", err0, doneCnt); end
  endtask

  task automatic test_random_frames();
    for (int round = 0; round < 4; round++) begin
      clearMon();
      frameQ.delete();
      for (int f = 0; f < 5; f++) begin
        int nJunk;
        int n;
        logic [7:0] x;
        logic [7:0] b;
        nJunk = int'($urandom_range(0, 2));
        for (int j = 0; j < nJunk; j++) begin
          b = 8'($urandom_range(0, 255));
          frameQ.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        n = int'($urandom_range(0, 4));
        frameQ.push_back(8'hA5);
        frameQ.push_back(8'h00);
        frameQ.push_back(8'(n));
        x = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          frameQ.push_back(b);
        end
        if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
        frameQ.push_back(x);
      end
      modelStream();
      sendStream(3);
      checks++; if (wrQ0.size() != expQ0.size()) begin errors++; $display("[TB] FAIL rand%0d_wcount got %0d want %0d", round, wrQ0.size(), expQ0.size()); end
      for (int k = 0; k < expQ0.size(); k++) begin
        checks++; if (wrQ0[k] !== expQ0[k]) begin errors++; $display("[TB] FAIL rand%0d_write%0d got %h want %h", round, k, wrQ0[k], expQ0[k]); end
        checks++; if (wrQ1[k] !== expQ1[k]) begin errors++; $display("[TB] FAIL rand%0d_write_base%0d got %h want %h", round, k, wrQ1[k], expQ1[k]); end
      end
      checks++; if (doneCnt != expDone) begin errors++; $display("[TB] FAIL rand%0d_done got %0d want %0d", round, doneCnt, expDone); end
      checks++; if (err0 !== expErr) begin errors++; $display("[TB] FAIL rand%0d_err got %b want %b", round, err0, expErr); end
      checks++; if (rdyLowCnt != expWords) begin errors++; $display("[TB] FAIL rand%0d_ready_low got %0d want %0d", round, rdyLowCnt, expWords); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_empty_frame();
    test_gaps_three_words();
    test_garbage();
    test_wrap();
    test_reset_mid_frame();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream image loader that acts as the write-side initiator for the 32-bit instruction/data memory (16-bit `addr`, 32-bit `wdata`, `we` written on posedge `clk`). It accepts a framed byte stream from a host-link receiver, assembles big-endian 32-bit words and writes them to consecutive memory addresses. This lets the memory image be loaded at run time rather than only at elaboration. The block sits between the serial receiver and the memory write port; the CPU is held off while `busy` is high.

## Interface
- `BASE_ADDR`, 16'h0000, address of the first word written in every frame
- `SYNC_BYTE`, 8'hA5, frame start marker
- `clk`  in  1  system clock, all state on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept a byte
- `addr`  out  16  memory address
- `wdata`  out  32  memory write data
- `we`  out  1  memory write enable, one-cycle pulse per word
- `busy`  out  1  frame in progress (state != IDLE)
- `done`  out  1  one-cycle pulse, frame finished
- `err`  out  1  sticky checksum error for the last frame

## Operation
- Byte accepted on a posedge where `rx_valid && rx_ready`. There is no other handshake.
- Frame format:
  - SYNC_BYTE
  - LEN_H, LEN_L: word count N, 16 bits, big-endian
  - 4·N data bytes, MSB first per word
  - CSUM: XOR of all 4·N data bytes
- States and transitions:
  - IDLE: rx_ready=1. A byte equal to SYNC_BYTE moves to LEN_H and clears `err`. Any other byte is discarded silently.
  - LEN_H: rx_ready=1. Latch count[15:8], go to LEN_L.
  - LEN_L: rx_ready=1. Latch count[7:0]. If N==0 go to CSUM, else go to DATA with byte index 0 and word index 0.
  - DATA: rx_ready=1. Shift the byte into the word register and XOR it into the running checksum. On byte index 3, go to WRITE.
  - WRITE: rx_ready=0, we=1, addr=BASE_ADDR+word index (mod 2^16), wdata=assembled word. Increment word index. If word index becomes N go to CSUM, else go to DATA.
  - CSUM: rx_ready=1. On accept, compare the byte to the running checksum. Set `err` on mismatch, pulse `done` next cycle, return to IDLE.
- Words already written are never rolled back; `err` only flags the frame.
- Running checksum and byte index are cleared on SYNC accept.
- `addr` and `wdata` are registered. They hold their last values outside WRITE.
- Address arithmetic is 16-bit unsigned and wraps 16'hFFFF -> 16'h0000 without error.
- `rx_valid` may drop between any bytes; the FSM simply waits.
- `rx_ready` is a combinational decode of the state.

## Timing
- Reset (async assert) values:
  - state=IDLE
  - `addr`=BASE_ADDR, `wdata`=0, `we`=0, `done`=0, `err`=0, `busy`=0
  - Bytes presented while `rst_n`=0 are ignored.
- 4th byte of a word accepted at edge k:
  - `we`=1 during cycle k→k+1.
  - Memory captures the word at edge k+1.
  - `rx_ready`=0 in that same cycle.
- Sustained throughput is 4 bytes per 5 cycles.
- CSUM accepted at edge k:
  - `done`=1 and `err` valid during cycle k→k+1.
  - `busy`=0 from edge k.
  - A new SYNC may be accepted at edge k+1.
- Reset mid-frame:
  - `we` drops immediately and the FSM returns to IDLE.
  - Words already written remain in memory.
  - The remainder of the interrupted frame is discarded as non-sync bytes, unless a byte equals SYNC_BYTE.
- Memory `data` read path is unused by this block.

## Test plan
- Single word: A5 00 01 DE AD BE EF 22 -> one `we` pulse with addr=0000, wdata=DEADBEEF; `done`=1, `err`=0; rx_ready low exactly one cycle.
- Empty frame: A5 00 00 00 -> no `we`; `done` pulses; `err`=0. Repeat with CSUM=01 -> `err`=1, held until the next A5 is accepted.
- Three words 00000001/00000002/00000003, CSUM 00, with `rx_valid` gaps of 0–3 cycles -> writes at 0000/0001/0002 in order; no bytes lost during WRITE backpressure.
- Garbage 00 FF 5A, then a valid one-word frame -> garbage ignored, `busy` stays 0 until A5, frame loads correctly.
- BASE_ADDR=16'hFFFF, N=2 -> writes at FFFF then 0000.
- Assert `rst_n` after 6 of 8 data bytes of N=2 -> `we`=0 immediately, word 0 retained, `busy`=0; a following full frame loads normally.
